// File: rtl/counter_snapshot_reader.sv
// rtl/counter_snapshot_reader.sv - atomic 64-bit counter snapshot streamed out LS slice first
//
// Captures the live 64-bit count on snap_req and streams it as N = 64/W
// beats of W bits over a valid/ready interface, so a narrow consumer reads a
// consistent value with no tearing between slices.
//
// Ports:
//   clk        - clock, all logic on posedge
//   rst_n      - asynchronous active-low reset
//   count      - live counter value to sample
//   snap_req   - capture request, sampled each posedge
//   out_ready  - consumer accepts the current beat
//   out_valid  - current beat valid
//   out_data   - current W-bit slice (0 when out_valid is low)
//   out_last   - final beat of the snapshot
//   busy       - a snapshot is being streamed
//   overrun    - sticky: a request was dropped while busy
module counter_snapshot_reader #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [63:0]  count,
  input  logic         snap_req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         busy,
  output logic         overrun
);

  localparam int N  = 64 / W;
  localparam int IW = $clog2(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } state_t;

  state_t        state;
  logic [63:0]   snap;
  logic [IW-1:0] idx;
  logic          at_last;

  assign at_last = (idx == LAST_IDX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      snap    <= '0;
      idx     <= '0;
      overrun <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (snap_req) begin
            snap    <= count;
            idx     <= '0;
            overrun <= 1'b0;
            state   <= STREAM;
          end
        end
        STREAM: begin
          if (out_ready && at_last) begin
            // Last beat leaves this cycle: a request here is taken with no bubble.
            idx <= '0;
            if (snap_req) begin
              snap    <= count;
              overrun <= 1'b0;
            end else begin
              state <= IDLE;
            end
          end else begin
            if (out_ready) begin
              idx <= idx + IW'(1);
            end
            if (snap_req) begin
              overrun <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are decoded purely from registered state, so nothing depends
  // combinationally on out_ready or snap_req.
  always_comb begin
    out_valid = (state == STREAM);
    busy      = (state == STREAM);
    out_last  = (state == STREAM) && at_last;
    out_data  = '0;
    if (state == STREAM) begin
      for (int i = 0; i < N; i++) begin
        if (idx == IW'(i)) begin
          out_data = snap[i*W +: W];
        end
      end
    end
  end

endmodule

// File: tb/tb_counter_snapshot_reader.sv
// tb/tb_counter_snapshot_reader.sv - self-checking bench for counter_snapshot_reader (W=8 and W=32)
module tb_counter_snapshot_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] count = '0;
  logic        snap_req = 1'b0;
  logic        out_ready = 1'b1;

  logic        d8_valid, d8_last, d8_busy, d8_ovr;
  logic [7:0]  d8_data;
  logic        d32_valid, d32_last, d32_busy, d32_ovr;
  logic [31:0] d32_data;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  counter_snapshot_reader #(.W(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .count(count), .snap_req(snap_req), .out_ready(out_ready),
    .out_valid(d8_valid), .out_data(d8_data), .out_last(d8_last), .busy(d8_busy), .overrun(d8_ovr)
  );

  counter_snapshot_reader #(.W(32)) dut32 (
    .clk(clk), .rst_n(rst_n), .count(count), .snap_req(snap_req), .out_ready(out_ready),
    .out_valid(d32_valid), .out_data(d32_data), .out_last(d32_last), .busy(d32_busy), .overrun(d32_ovr)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: each DUT holds the not-yet-sent part of the snapshot and the
  // number of beats left; the current beat is the low slice of what remains.
  int          wd [2] = '{8, 32};
  logic [63:0] m_rem [2] = '{64'd0, 64'd0};
  int          m_left [2] = '{0, 0};
  bit          m_ovr [2] = '{1'b0, 1'b0};

  always @(posedge clk or negedge rst_n) begin
    for (int d = 0; d < 2; d++) begin
      if (!rst_n) begin
        m_rem[d] = '0; m_left[d] = 0; m_ovr[d] = 1'b0;
      end else if (m_left[d] == 0 || (out_ready && m_left[d] == 1)) begin
        // Idle, or final beat leaving: a request starts a fresh snapshot.
        if (snap_req) begin
          m_rem[d] = count; m_left[d] = 64 / wd[d]; m_ovr[d] = 1'b0;
        end else begin
          m_left[d] = 0;
        end
      end else begin
        if (out_ready) begin
          m_rem[d] = m_rem[d] >> wd[d];
          m_left[d] = m_left[d] - 1;
        end
        if (snap_req) m_ovr[d] = 1'b1;
      end
    end
  end

  bit checking = 1'b1;

  always @(negedge clk) begin
    if (checking) begin
      chk("w8_valid", {63'd0, d8_valid}, {63'd0, m_left[0] > 0});
      chk("w8_data", {56'd0, d8_data}, (m_left[0] > 0) ? {56'd0, m_rem[0][7:0]} : 64'd0);
      chk("w8_last", {63'd0, d8_last}, {63'd0, m_left[0] == 1});
      chk("w8_busy", {63'd0, d8_busy}, {63'd0, m_left[0] > 0});
      chk("w8_overrun", {63'd0, d8_ovr}, {63'd0, m_ovr[0]});
      chk("w32_valid", {63'd0, d32_valid}, {63'd0, m_left[1] > 0});
      chk("w32_data", {32'd0, d32_data}, (m_left[1] > 0) ? {32'd0, m_rem[1][31:0]} : 64'd0);
      chk("w32_last", {63'd0, d32_last}, {63'd0, m_left[1] == 1});
      chk("w32_busy", {63'd0, d32_busy}, {63'd0, m_left[1] > 0});
      chk("w32_overrun", {63'd0, d32_ovr}, {63'd0, m_ovr[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    snap_req = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < n; i++) step();
  endtask

  logic [7:0]  exp1 [8] = '{8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [63:0] cap;
  logic [63:0] recv;
  int          beats;

  initial begin
    step(); step();
    chk("reset_valid", {63'd0, d8_valid}, 64'd0);
    chk("reset_busy", {63'd0, d8_busy}, 64'd0);
    chk("reset_data32", {32'd0, d32_data}, 64'd0);
    rst_n = 1'b1;
    step();

    // Basic 8-beat snapshot, LS byte first.
    count = 64'h0123_4567_89AB_CDEF;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    count = 64'hFFFF_FFFF_FFFF_FFFF;
    for (int i = 0; i < 8; i++) begin
      chk("basic_beat", {56'd0, d8_data}, {56'd0, exp1[i]});
      chk("basic_last", {63'd0, d8_last}, {63'd0, i == 7});
      step();
    end
    chk("basic_busy_after", {63'd0, d8_busy}, 64'd0);

    // Atomicity under backpressure: count keeps moving, ready is 1,0,0,...
    count = 64'h1122_3344_5566_7788;
    cap = count;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    recv = '0;
    beats = 0;
    for (int k = 0; k < 40; k++) begin
      out_ready = (k % 3 == 0);
      #1;
      if (d8_valid && out_ready) begin
        recv = recv | ({56'd0, d8_data} << (8 * beats));
        beats++;
      end
      step();
      count = count + 64'd1;
    end
    chk("atomic_beats", 64'(beats), 64'd8);
    chk("atomic_value", recv, cap);
    drain(3);

    // Overrun: request at beat 3 is dropped, stream unaffected.
    count = 64'hA5A5_0000_1111_2222;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step(); step(); step();
    snap_req = 1'b1;
    count = 64'h9999_9999_9999_9999;
    step();
    snap_req = 1'b0;
    chk("overrun_set", {63'd0, d8_ovr}, 64'd1);
    chk("overrun_beat4", {56'd0, d8_data}, 64'h00);
    step(); step(); step(); step();
    chk("overrun_idle", {63'd0, d8_busy}, 64'd0);
    chk("overrun_sticky", {63'd0, d8_ovr}, 64'd1);
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("overrun_clear", {63'd0, d8_ovr}, 64'd0);
    drain(9);

    // Back-to-back: request on the last-beat transfer cycle.
    count = 64'h0707_0707_0707_0707;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    for (int i = 0; i < 7; i++) step();
    chk("b2b_last_before", {63'd0, d8_last}, 64'd1);
    count = 64'h5;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("b2b_valid", {63'd0, d8_valid}, 64'd1);
    chk("b2b_data", {56'd0, d8_data}, 64'h05);
    chk("b2b_overrun", {63'd0, d8_ovr}, 64'd0);
    drain(9);

    // Reset mid-stream at beat 4.
    count = 64'hCCCC_DDDD_EEEE_FFFF;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    step(); step(); step(); step();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", {63'd0, d8_valid}, 64'd0);
    chk("rst_data", {56'd0, d8_data}, 64'd0);
    chk("rst_last", {63'd0, d8_last}, 64'd0);
    chk("rst_busy", {63'd0, d8_busy}, 64'd0);
    step(); step();
    rst_n = 1'b1;
    step(); step(); step();
    chk("rst_after_valid", {63'd0, d8_valid}, 64'd0);

    // W=32: two beats, low word first.
    count = 64'hDEAD_BEEF_CAFE_F00D;
    snap_req = 1'b1;
    step();
    snap_req = 1'b0;
    chk("w32_beat0", {32'd0, d32_data}, 64'hCAFE_F00D);
    chk("w32_last0", {63'd0, d32_last}, 64'd0);
    step();
    chk("w32_beat1", {32'd0, d32_data}, 64'hDEAD_BEEF);
    chk("w32_last1", {63'd0, d32_last}, 64'd1);
    step();
    chk("w32_busy_after", {63'd0, d32_busy}, 64'd0);
    drain(8);

    checking = 1'b0;
    step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
